// File: rtl/avmm_slave_timeout_guard.sv
// AVMM slave-side guard: passes single transactions through, aborts ones stalled too long.
// Optional error log (address/direction/count) enabled by defining AVMM_TMO_ERR_LOG_EN.
module avmm_slave_timeout_guard #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int DRAIN_CYCLES   = 4,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                  mm_clk,
  input  logic                  mm_reset,
  output logic                  s_waitrequest,
  input  logic                  s_write,
  input  logic                  s_read,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_writedata,
  output logic [DATA_WIDTH-1:0] s_readdata,
  input  logic                  m_waitrequest,
  output logic                  m_write,
  output logic                  m_read,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_writedata,
  input  logic [DATA_WIDTH-1:0] m_readdata,
  input  logic                  i_clear_err,
  output logic                  o_timeout_pulse,
  output logic                  o_timeout_sticky
`ifdef AVMM_TMO_ERR_LOG_EN
  ,
  output logic [ADDR_WIDTH-1:0] o_err_addr,
  output logic                  o_err_is_write,
  output logic [15:0]           o_err_count
`endif
);

  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [DCW-1:0] DRN_LAST = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ABORT,
    ST_DRAIN
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [DCW-1:0] r_dcnt;
  logic           r_pulse;
  logic           r_sticky;

  logic w_cmd;
  logic w_pass;

  assign w_cmd  = s_read | s_write;
  assign w_pass = (r_state == ST_IDLE) | (r_state == ST_WAIT);

  assign m_read      = w_pass & s_read;
  assign m_write     = w_pass & s_write;
  assign m_addr      = s_addr;
  assign m_writedata = s_writedata;

  always_comb begin
    s_waitrequest = m_waitrequest;
    s_readdata    = m_readdata;
    unique case (r_state)
      ST_IDLE, ST_WAIT: begin
        s_waitrequest = m_waitrequest;
        s_readdata    = m_readdata;
      end
      ST_ABORT: begin
        s_waitrequest = 1'b0;
        s_readdata    = TIMEOUT_DATA;
      end
      ST_DRAIN: begin
        s_waitrequest = 1'b1;
      end
    endcase
  end

  assign o_timeout_pulse  = r_pulse;
  assign o_timeout_sticky = r_sticky;

`ifdef AVMM_TMO_ERR_LOG_EN
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic                  r_err_is_write;
  logic [15:0]           r_err_count;

  assign o_err_addr     = r_err_addr;
  assign o_err_is_write = r_err_is_write;
  assign o_err_count    = r_err_count;
`endif

  // IDLE and WAIT share the counting path so cycle 0 of a command is counted.
  always_ff @(posedge mm_clk) begin
    if (mm_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_dcnt   <= '0;
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
`ifdef AVMM_TMO_ERR_LOG_EN
      r_err_addr     <= '0;
      r_err_is_write <= 1'b0;
      r_err_count    <= '0;
`endif
    end else begin
      r_pulse <= 1'b0;
      if (i_clear_err) begin
        r_sticky <= 1'b0;
`ifdef AVMM_TMO_ERR_LOG_EN
        r_err_count <= '0;
`endif
      end
      unique case (r_state)
        ST_IDLE, ST_WAIT: begin
          if (!w_cmd || !m_waitrequest) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_pulse <= 1'b1;
            r_state <= ST_ABORT;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_state <= ST_WAIT;
          end
        end
        ST_ABORT: begin
          r_sticky <= 1'b1;
          r_dcnt   <= '0;
          r_state  <= ST_DRAIN;
`ifdef AVMM_TMO_ERR_LOG_EN
          r_err_addr     <= s_addr;
          r_err_is_write <= s_write;
          if (i_clear_err)
            r_err_count <= 16'd1;
          else if (r_err_count != 16'hFFFF)
            r_err_count <= r_err_count + 16'd1;
`endif
        end
        ST_DRAIN: begin
          if (r_dcnt == DRN_LAST) begin
            r_dcnt  <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_dcnt <= r_dcnt + DCW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_slave_timeout_guard.sv
// Directed scoreboard bench for avmm_slave_timeout_guard (TIMEOUT=8, DRAIN=4).
// Define AVMM_TMO_ERR_LOG_EN to also exercise the error log.
module tb_avmm_slave_timeout_guard;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          mm_clk = 1'b0;
  logic          mm_reset;
  logic          s_waitrequest;
  logic          s_write;
  logic          s_read;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_writedata;
  logic [DW-1:0] s_readdata;
  logic          m_waitrequest;
  logic          m_write;
  logic          m_read;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_writedata;
  logic [DW-1:0] m_readdata;
  logic          i_clear_err;
  logic          o_timeout_pulse;
  logic          o_timeout_sticky;
`ifdef AVMM_TMO_ERR_LOG_EN
  logic [AW-1:0] o_err_addr;
  logic          o_err_is_write;
  logic [15:0]   o_err_count;
`endif

  always #5 mm_clk = ~mm_clk;

  avmm_slave_timeout_guard #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(8),
    .DRAIN_CYCLES  (4),
    .TIMEOUT_DATA  (32'hDEAD_BEEF)
  ) dut (
    .mm_clk          (mm_clk),
    .mm_reset        (mm_reset),
    .s_waitrequest   (s_waitrequest),
    .s_write         (s_write),
    .s_read          (s_read),
    .s_addr          (s_addr),
    .s_writedata     (s_writedata),
    .s_readdata      (s_readdata),
    .m_waitrequest   (m_waitrequest),
    .m_write         (m_write),
    .m_read          (m_read),
    .m_addr          (m_addr),
    .m_writedata     (m_writedata),
    .m_readdata      (m_readdata),
    .i_clear_err     (i_clear_err),
    .o_timeout_pulse (o_timeout_pulse),
    .o_timeout_sticky(o_timeout_sticky)
`ifdef AVMM_TMO_ERR_LOG_EN
    ,
    .o_err_addr      (o_err_addr),
    .o_err_is_write  (o_err_is_write),
    .o_err_count     (o_err_count)
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_asrt = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge mm_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge mm_clk);
  endtask

  task automatic want(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic got(input logic [31:0] obs);
    exp_t x;
    n_asrt++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%h", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic drive(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic wq, input logic [31:0] rdat);
    s_read        = rd;
    s_write       = wr;
    s_addr        = a;
    s_writedata   = wd;
    m_waitrequest = wq;
    m_readdata    = rdat;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Command with a hung slave: abort on cycle 8, drain on 9..12 while a
  // follow-up read waits, follow-up accepted on cycle 13.
  task automatic stuck(input logic wr, input logic [31:0] a, input logic clr);
    for (int c = 0; c <= 8; c++) begin
      tick();
      drive(!wr, wr, a, 32'hA5A5_0000 | a, 1'b1, 32'h0);
      i_clear_err = clr && (c == 8);
      want("stk_pulse", 32'(c == 8));
      want("stk_swait", 32'(c != 8));
      want("stk_mcmd",  32'(c != 8));
      if (c == 8) want("stk_rdata", 32'hDEAD_BEEF);
      sample();
      got(o_timeout_pulse);
      got(s_waitrequest);
      got(wr ? m_write : m_read);
      if (c == 8) got(s_readdata);
    end
    for (int d = 0; d < 4; d++) begin
      tick();
      i_clear_err = 1'b0;
      drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h5555);
      want("drn_swait", 32'h1);
      want("drn_mread", 32'h0);
      want("drn_pulse", 32'h0);
      if (d == 0) want("drn_sticky", 32'h1);
      sample();
      got(s_waitrequest);
      got(m_read);
      got(o_timeout_pulse);
      if (d == 0) got(o_timeout_sticky);
    end
    tick();
    want("acc_mread", 32'h1);
    want("acc_swait", 32'h0);
    want("acc_rdata", 32'h5555);
    sample();
    got(m_read);
    got(s_waitrequest);
    got(s_readdata);
    tick();
    idle();
  endtask

  task automatic clear_pulse();
    tick();
    i_clear_err = 1'b1;
    tick();
    i_clear_err = 1'b0;
    want("clr_sticky", 32'h0);
    sample();
    got(o_timeout_sticky);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mm_reset    = 1'b1;
    i_clear_err = 1'b0;
    idle();
    tick();
    tick();
    want("rst_pulse",  32'h0);
    want("rst_sticky", 32'h0);
    want("rst_mread",  32'h0);
    want("rst_mwrite", 32'h0);
    sample();
    got(o_timeout_pulse);
    got(o_timeout_sticky);
    got(m_read);
    got(m_write);
    tick();
    mm_reset = 1'b0;

    // Read 0x10, slave stalls 3 cycles then returns 0x1234
    for (int c = 0; c < 4; c++) begin
      tick();
      drive(1'b1, 1'b0, 32'h10, 32'h0, c < 3, 32'h1234);
      want("s1_mread", 32'h1);
      want("s1_maddr", 32'h10);
      want("s1_swait", 32'(c < 3));
      want("s1_pulse", 32'h0);
      if (c == 3) want("s1_rdata", 32'h1234);
      sample();
      got(m_read);
      got(m_addr);
      got(s_waitrequest);
      got(o_timeout_pulse);
      if (c == 3) got(s_readdata);
    end
    tick();
    idle();
    want("s1_sticky", 32'h0);
    sample();
    got(o_timeout_sticky);

    // Read with hung slave, then clear the sticky flag
    stuck(1'b0, 32'h20, 1'b0);
    want("s2_sticky_after", 32'h1);
    sample();
    got(o_timeout_sticky);
    clear_pulse();

    // Write released on cycle 7: last legal completion cycle
    for (int c = 0; c < 8; c++) begin
      tick();
      drive(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, c < 7, 32'h0);
      want("s3_mwrite", 32'h1);
      want("s3_mwdata", 32'hCAFE_F00D);
      want("s3_swait",  32'(c < 7));
      want("s3_pulse",  32'h0);
      sample();
      got(m_write);
      got(m_writedata);
      got(s_waitrequest);
      got(o_timeout_pulse);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      idle();
      want("s3_pulse_post",  32'h0);
      want("s3_sticky_post", 32'h0);
      sample();
      got(o_timeout_pulse);
      got(o_timeout_sticky);
    end

    // Abort coinciding with i_clear_err: set wins; later clear works
    stuck(1'b0, 32'h34, 1'b1);
    want("s4_sticky_set", 32'h1);
    sample();
    got(o_timeout_sticky);
    clear_pulse();

    // Reset in cycle 4 of WAIT
    for (int c = 0; c < 5; c++) begin
      tick();
      drive(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 32'h0);
      mm_reset = (c == 4);
    end
    tick();
    mm_reset = 1'b0;
    idle();
    want("s5_pulse",  32'h0);
    want("s5_sticky", 32'h0);
    want("s5_mread",  32'h0);
    sample();
    got(o_timeout_pulse);
    got(o_timeout_sticky);
    got(m_read);
    // Counter must restart from 0: abort lands exactly on cycle 8 again
    stuck(1'b0, 32'h54, 1'b0);

`ifdef AVMM_TMO_ERR_LOG_EN
    clear_pulse();
    want("s6_cnt0", 32'h0);
    sample();
    got(32'(o_err_count));
    stuck(1'b0, 32'h40, 1'b0);
    want("s6_addr1",  32'h40);
    want("s6_isw1",   32'h0);
    want("s6_count1", 32'h1);
    sample();
    got(o_err_addr);
    got(32'(o_err_is_write));
    got(32'(o_err_count));
    stuck(1'b1, 32'h44, 1'b0);
    want("s6_addr2",  32'h44);
    want("s6_isw2",   32'h1);
    want("s6_count2", 32'h2);
    sample();
    got(o_err_addr);
    got(32'(o_err_is_write));
    got(32'(o_err_count));
`endif

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
